seg_display_scan: RTL

SEG_DISPLAY_SCAN -- requirements
Module: seg_display_scan

---
 rtl/seg_pkg.sv | 40 ++++
 rtl/seg_display_scan_if.sv | 28 ++
 rtl/seg7_decode.sv | 26 ++
 rtl/seg_display_scan.sv | 129 ++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 4-digit 7-segment scanner.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned SEG_W      = 7;

    typedef logic [3:0] digit_t;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_MINUS = 7'h3F;

    // One complete display image: four digit codes plus their decimal points.
    typedef struct packed {
        logic [NUM_DIGITS-1:0]   dp;
        digit_t [NUM_DIGITS-1:0] dig;
    } disp_t;

    // Bit i set means digit i is a leading zero to be suppressed; digit 0 always shows.
    function automatic logic [NUM_DIGITS-1:0] lz_blank_mask(input disp_t v, input logic lz_en);
        logic [NUM_DIGITS-1:0] m;
        m[3] = lz_en && (v.dig[3] == 4'd0);
        m[2] = m[3]  && (v.dig[2] == 4'd0);
        m[1] = m[2]  && (v.dig[1] == 4'd0);
        m[0] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/seg_display_scan_if.sv
// Host-side bundle for the display scanner: digit update bus, controls and pin outputs.
interface seg_display_scan_if;
    import seg_pkg::*;

    logic                  en;
    digit_t                d0;
    digit_t                d1;
    digit_t                d2;
    digit_t                d3;
    logic [NUM_DIGITS-1:0] dp_sel;
    logic                  upd;
    logic                  blank_lz;
    logic [NUM_DIGITS-1:0] an_n;
    logic [SEG_W-1:0]      seg_n;
    logic                  dp_n;
    logic                  frame_tick;

    modport master (
        output en, d0, d1, d2, d3, dp_sel, upd, blank_lz,
        input  an_n, seg_n, dp_n, frame_tick
    );

    modport slave (
        input  en, d0, d1, d2, d3, dp_sel, upd, blank_lz,
        output an_n, seg_n, dp_n, frame_tick
    );

endinterface

// File: rtl/seg7_decode.sv
// Combinational digit-code to active-low segment pattern; non-decimal codes show a minus.
module seg7_decode
    import seg_pkg::*;
(
    input  digit_t           code,
    output logic [SEG_W-1:0] seg_n_c
);

    always_comb begin
        seg_n_c = SEG_MINUS;
        case (code)
            4'd0:    seg_n_c = SEG_0;
            4'd1:    seg_n_c = SEG_1;
            4'd2:    seg_n_c = SEG_2;
            4'd3:    seg_n_c = SEG_3;
            4'd4:    seg_n_c = SEG_4;
            4'd5:    seg_n_c = SEG_5;
            4'd6:    seg_n_c = SEG_6;
            4'd7:    seg_n_c = SEG_7;
            4'd8:    seg_n_c = SEG_8;
            4'd9:    seg_n_c = SEG_9;
            default: seg_n_c = SEG_MINUS;
        endcase
    end

endmodule

// File: rtl/seg_display_scan.sv
// Time-multiplexed 4-digit 7-segment driver with anode dead time, leading-zero
// blanking and frame-synchronous (tear-free) update of the displayed value.
module seg_display_scan
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned DEAD     = 500
) (
    input  logic               clk,
    input  logic               rst_n,
    seg_display_scan_if.slave  bus
);

    localparam int unsigned     CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    disp_t                 stage_q, stage_d;
    disp_t                 shadow_q, shadow_d;
    logic                  pend_q, pend_d;
    logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
    logic [SEG_W-1:0]      seg_n_q, seg_n_d;
    logic                  dp_n_q, dp_n_d;
    logic                  frame_tick_q, frame_tick_d;

    disp_t                 in_c;
    logic                  wrap_c;
    logic                  boundary_c;
    logic                  lit_c;
    logic [NUM_DIGITS-1:0] blank_c;
    logic [SEG_W-1:0]      seg_dec_c;

    assign in_c.dp  = bus.dp_sel;
    assign in_c.dig = {bus.d3, bus.d2, bus.d1, bus.d0};

    seg7_decode u_dec (
        .code    (shadow_q.dig[idx_q]),
        .seg_n_c (seg_dec_c)
    );

    // Prescaler and digit index; disabled scan parks at slot 0, count 0.
    always_comb begin
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wrap_c     = 1'b0;
        boundary_c = 1'b0;
        if (!bus.en) begin
            cnt_d = '0;
            idx_d = '0;
        end else begin
            wrap_c     = (cnt_q == CNT_LAST);
            boundary_c = wrap_c && (idx_q == IDX_LAST);
            if (wrap_c) begin
                cnt_d = '0;
                idx_d = idx_q + IDX_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Staging/shadow: a coincident upd bypasses staging so the fresh value wins.
    always_comb begin
        stage_d  = stage_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        if (bus.upd) begin
            stage_d = in_c;
            pend_d  = 1'b1;
        end
        if (boundary_c) begin
            if (bus.upd) begin
                shadow_d = in_c;
                pend_d   = 1'b0;
            end else if (pend_q) begin
                shadow_d = stage_q;
                pend_d   = 1'b0;
            end
        end
    end

    // Pin values for the next cycle; anything not lit is fully dark.
    always_comb begin
        blank_c      = lz_blank_mask(shadow_q, bus.blank_lz);
        lit_c        = bus.en && (cnt_q >= CNT_DEAD) && !blank_c[idx_q];
        an_n_d       = '1;
        seg_n_d      = SEG_BLANK;
        dp_n_d       = 1'b1;
        frame_tick_d = boundary_c;
        if (lit_c) begin
            an_n_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_n_d = seg_dec_c;
            dp_n_d  = ~shadow_q.dp[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            stage_q      <= '0;
            shadow_q     <= '0;
            pend_q       <= 1'b0;
            an_n_q       <= '1;
            seg_n_q      <= SEG_BLANK;
            dp_n_q       <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            stage_q      <= stage_d;
            shadow_q     <= shadow_d;
            pend_q       <= pend_d;
            an_n_q       <= an_n_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.an_n       = an_n_q;
    assign bus.seg_n      = seg_n_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.frame_tick = frame_tick_q;

endmodule
